// File: rtl/outwr_pkg.sv
// outwr_pkg: shared record type, framing constants and serialiser states
package outwr_pkg;
  typedef struct packed {
    logic [15:0] addr;
    logic [23:0] value;
  } record_t;
  localparam int RECORD_BYTES = 5;
  localparam logic [7:0] FRAME_SOF = 8'hA5;
  typedef enum logic [1:0] {IDLE, HDR, SEND, CHK} state_t;
endpackage

// File: rtl/outwr_fifo.sv
// outwr_fifo: record FIFO, pointers wrap modulo DEPTH (power of 2)
// Ports: clk, reset (sync, active-high); push/din write; pop advances head;
//        head = oldest record, count = records held, full/empty from registered count.
module outwr_fifo
  import outwr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  record_t                  din,
  input  logic                     pop,
  output record_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  record_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    head = mem_q[rd_q];
    count = cnt_q;
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
endmodule

// File: rtl/result_stream_writer.sv
// result_stream_writer: dedups result records, buffers them and streams them out as bytes
// Ports: clk, reset (sync, active-high); data/enable = result bus from the processor;
//        tx_data/tx_valid/tx_ready = byte stream (MSB first); fifo_count, overflow (sticky),
//        drop_count (saturating), busy = work pending.
// Optional OUTWR_FRAME_EN: each record framed as A5, 5 payload bytes, XOR checksum.
module result_stream_writer
  import outwr_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [39:0]              data,
  input  logic                     enable,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     busy
);
  record_t head, sh_q, sh_d;
  logic full, empty, push, pop, is_new;
  logic [39:0] last_rec_q, last_rec_d;
  logic last_valid_q, last_valid_d, overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [2:0] idx_q, idx_d;
  state_t state_q, state_d;
  outwr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(record_t'(data)), .pop(pop),
    .head(head), .count(fifo_count), .full(full), .empty(empty)
  );
  // A new record updates the dedup register even when it has to be dropped.
  always_comb begin
    is_new = enable && (!last_valid_q || data != last_rec_q);
    push = is_new && !full;
    last_rec_d = is_new ? data : last_rec_q;
    last_valid_d = last_valid_q | is_new;
    overflow_d = overflow_q | (is_new && full);
    drop_cnt_d = (is_new && full && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    pop = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        sh_d = head;
        idx_d = '0;
`ifdef OUTWR_FRAME_EN
        state_d = HDR;
`else
        state_d = SEND;
`endif
      end
`ifdef OUTWR_FRAME_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_data = FRAME_SOF;
        if (tx_ready) state_d = SEND;
      end
      CHK: begin
        tx_valid = 1'b1;
        tx_data = sh_q[39:32] ^ sh_q[31:24] ^ sh_q[23:16] ^ sh_q[15:8] ^ sh_q[7:0];
        if (tx_ready) state_d = IDLE;
      end
`endif
      SEND: begin
        tx_valid = 1'b1;
        tx_data = 8'(sh_q >> {3'(3'(RECORD_BYTES - 1) - idx_q), 3'b000});
        if (tx_ready) begin
          idx_d = idx_q + 3'd1;
`ifdef OUTWR_FRAME_EN
          if (idx_q == 3'(RECORD_BYTES - 1)) state_d = CHK;
`else
          if (idx_q == 3'(RECORD_BYTES - 1)) state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    overflow = overflow_q;
    drop_count = drop_cnt_q;
    busy = !empty || state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rec_q <= '0;
      last_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
    end else begin
      last_rec_q <= last_rec_d;
      last_valid_q <= last_valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: tb/tb_result_stream_writer.sv
// tb_result_stream_writer: scoreboard bench for result_stream_writer
module tb_result_stream_writer;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, tx_ready = 1'b0;
  logic [39:0] data = '0;
  logic [7:0] tx_data;
  logic tx_valid, overflow, busy;
  logic [CW-1:0] fifo_count;
  logic [CNT_W-1:0] drop_count;
  logic [7:0] exp_q[$];
  int checks = 0, failures = 0, n_rx = 0;
  logic hold_v = 1'b0;
  logic [7:0] hold_d = '0;
  result_stream_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .data(data), .enable(enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic expect_rec(logic [39:0] r);
`ifdef OUTWR_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
    for (int i = 0; i < 5; i++) exp_q.push_back(r[39-8*i -: 8]);
`ifdef OUTWR_FRAME_EN
    exp_q.push_back(r[39:32] ^ r[31:24] ^ r[23:16] ^ r[15:8] ^ r[7:0]);
`endif
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(int max);
    for (int i = 0; i < max && (busy || exp_q.size() != 0); i++) cyc(1);
    chk("drain_busy", 40'(busy), 40'd0);
    chk("drain_pending", 40'(exp_q.size()), 40'd0);
  endtask
  // Monitor: handshake happens at the next posedge, so sample mid-cycle.
  always @(negedge clk) begin
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("hold_valid", 40'(tx_valid), 40'd1);
        chk("hold_data", 40'(tx_data), 40'(hold_d));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%h required=none", tx_data);
        end else chk("byte", 40'(tx_data), 40'(exp_q.pop_front()));
        n_rx++;
      end
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
    end
  end
  initial begin
    int base;
    cyc(2);
    chk("rst_valid", 40'(tx_valid), 40'd0);
    chk("rst_count", 40'(fifo_count), 40'd0);
    chk("rst_overflow", 40'(overflow), 40'd0);
    chk("rst_drops", 40'(drop_count), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    reset = 1'b0;
    cyc(1);
    // 1: repeated record while enable stays high -> sent once
    tx_ready = 1'b1;
    data = 40'h0001_000005;
    enable = 1'b1;
    expect_rec(40'h0001_000005);
    cyc(10);
    enable = 1'b0;
    drain(100);
    chk("t1_count", 40'(fifo_count), 40'd0);
    // 2: A A B A -> A B A
    expect_rec(40'h1234_ABCDEF);
    expect_rec(40'h1234_ABCDEE);
    expect_rec(40'h1234_ABCDEF);
    enable = 1'b1;
    data = 40'h1234_ABCDEF;
    cyc(2);
    data = 40'h1234_ABCDEE;
    cyc(1);
    data = 40'h1234_ABCDEF;
    cyc(1);
    enable = 1'b0;
    drain(100);
    // 3: stalled sink; serialiser holds one blocker, FIFO fills, 3 drops
    tx_ready = 1'b0;
    data = 40'hFF00_000000;
    enable = 1'b1;
    expect_rec(40'hFF00_000000);
    cyc(1);
    enable = 1'b0;
    cyc(3);
    chk("t3_blocker_popped", 40'(fifo_count), 40'd0);
    for (int i = 0; i < DEPTH + 3; i++) begin
      data = {16'h3000, 24'(i)};
      enable = 1'b1;
      if (i < DEPTH) expect_rec({16'h3000, 24'(i)});
      cyc(1);
    end
    enable = 1'b0;
    chk("t3_count", 40'(fifo_count), 40'(DEPTH));
    chk("t3_overflow", 40'(overflow), 40'd1);
    chk("t3_drops", 40'(drop_count), 40'd3);
    chk("t3_busy", 40'(busy), 40'd1);
    tx_ready = 1'b1;
    drain(600);
    chk("t3_overflow_sticky", 40'(overflow), 40'd1);
    // 4: tx_ready toggling every cycle
    data = 40'h5A5A_C3C3C3;
    enable = 1'b1;
    expect_rec(40'h5A5A_C3C3C3);
    cyc(1);
    enable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tx_ready = ~tx_ready;
      cyc(1);
    end
    tx_ready = 1'b1;
    drain(100);
    // 5: reset after two bytes of a record with two more queued
    base = n_rx;
    for (int i = 1; i <= 3; i++) begin
      data = {16'h0C0C, 24'(i)};
      enable = 1'b1;
      expect_rec({16'h0C0C, 24'(i)});
      cyc(1);
    end
    enable = 1'b0;
    for (int i = 0; i < 50 && n_rx < base + 2; i++) @(negedge clk);
    chk("t5_two_bytes", 40'(n_rx - base >= 2), 40'd1);
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    cyc(1);
    reset = 1'b0;
    chk("t5_valid", 40'(tx_valid), 40'd0);
    chk("t5_count", 40'(fifo_count), 40'd0);
    chk("t5_overflow", 40'(overflow), 40'd0);
    chk("t5_drops", 40'(drop_count), 40'd0);
    chk("t5_busy", 40'(busy), 40'd0);
    cyc(3);
    chk("t5_stays_idle", 40'(tx_valid), 40'd0);
    // 6: single record, hand-computed byte stream
    tx_ready = 1'b1;
    data = 40'h0010_ABCDEF;
    enable = 1'b1;
`ifdef OUTWR_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h10);
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    exp_q.push_back(8'hEF);
`ifdef OUTWR_FRAME_EN
    exp_q.push_back(8'h99);
`endif
    cyc(1);
    enable = 1'b0;
    drain(100);
    chk("t6_count", 40'(fifo_count), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
